// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle through a single shared WIDTH+1-bit adder.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] ITERS    = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q;    // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;    // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opnd_q;  // multiplicand or divisor magnitude

    // Operand preparation on the incoming request
    logic             is_div_in, a_sgn_in, b_sgn_in, sa, sb, neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, fast;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        is_div_in = op[2];
        a_sgn_in  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_sgn_in  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa        = a_sgn_in & a[WIDTH-1];
        sb        = b_sgn_in & b[WIDTH-1];
        a_mag     = sa ? -a : a;
        b_mag     = sb ? -b : b;
        // Remainder takes the dividend's sign; quotient and product take the XOR
        neg_in    = (is_div_in && op[1]) ? sa : (sa ^ sb);
        div_zero  = is_div_in && (b == '0);
        div_ovf   = is_div_in && !op[0] && (a == MOST_NEG) && (b == '1);
        fast      = div_zero || div_ovf;
        fast_res  = '0;
        if (div_zero)
            fast_res = op[1] ? a : '1;
        else if (div_ovf)
            fast_res = op[1] ? '0 : a;
    end

    // Shared adder: multiply accumulates, divide subtracts via ~divisor + 1
    logic [WIDTH:0]   add_a, add_b;
    logic             cin;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    always_comb begin
        add_a = '0;
        add_b = '0;
        cin   = 1'b0;
        if (op_q[2]) begin
            add_a = {hi_q, lo_q[WIDTH-1]};
            add_b = ~{1'b0, opnd_q};
            cin   = 1'b1;
        end else begin
            add_a = {1'b0, hi_q};
            add_b = lo_q[0] ? {1'b0, opnd_q} : '0;
        end
        sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(cin);

        hi_nxt = '0;
        lo_nxt = '0;
        if (op_q[2]) begin
            // Carry out means the trial subtraction did not borrow
            if (sum[WIDTH+1]) begin
                hi_nxt = sum[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = add_a[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result selection from the final iteration's values
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   div_sel, div_fix, run_res;

    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_q ? -prod : prod;
        div_sel  = op_q[1] ? hi_nxt : lo_nxt;
        div_fix  = neg_q ? -div_sel : div_sel;
        run_res  = '0;
        if (op_q[2])
            run_res = div_fix;
        else if (op_q[1:0] == 2'b00)
            run_res = prod_fix[WIDTH-1:0];
        else
            run_res = prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = fast ? FIN : RUN;
            RUN:  if (cnt == CNT_W'(1)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; all datapath registers are reset, the design has no memories.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        neg_q  <= neg_in;
                        hi_q   <= '0;
                        lo_q   <= is_div_in ? a_mag : b_mag;
                        opnd_q <= is_div_in ? b_mag : a_mag;
                        if (fast) begin
                            cnt    <= '0;
                            result <= fast_res;
                        end else begin
                            cnt <= ITERS;
                        end
                    end
                end
                RUN: begin
                    cnt  <= cnt - CNT_W'(1);
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    if (cnt == CNT_W'(1))
                        result <= run_res;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances,
// latency, handshake, fast paths and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        start32;
    logic [2:0]  op32;
    logic [31:0] a32, b32;
    logic        busy32, done32;
    logic [31:0] result32;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  result8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 32-bit unit, wait for done, check latency/result/hold
    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat;
        op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        check({tag, " busy"}, 32'(busy32), 32'd1);
        lat = 0;
        while (!done32 && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result32, exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, " done drop"}, {30'd0, busy32, done32}, 32'd0);
        check({tag, " hold"}, result32, exp);
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] exp, input int exp_lat);
        int lat;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(result8), 32'(exp));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done drop"}, {30'd0, busy8, done8}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;
        repeat (2) @(negedge clk);
        check("reset32", {busy32, done32, result32[29:0]}, 32'd0);
        check("reset32 result", result32, 32'd0);
        check("reset8", {22'd0, busy8, done8, result8}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each run starts in the first IDLE cycle after done
        run32("mul",      3'b000, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 32);
        run32("mul_neg",  3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32);
        run32("mulh",     3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32);
        run32("mulhu",    3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32);
        run32("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run32("div",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32);
        run32("rem",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32);
        run32("divu",     3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 32);
        run32("remu",     3'b111, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32);
        run32("divu_z",   3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run32("remu_z",   3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 0);
        run32("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run32("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

        run8("mulhu8",    3'b011, 8'hFF, 8'hFF, 8'hFE, 8);
        run8("div8_ovf",  3'b100, 8'h80, 8'hFF, 8'h80, 0);

        // Mid-operation reset with start held and operands changing
        op32 = 3'b101; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0003;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrun busy", 32'(busy32), 32'd1);
        rst = 1'b1;
        start32 = 1'b0;
        #1;
        check("async rst flags", {30'd0, busy32, done32}, 32'd0);
        check("async rst result", result32, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run32("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit that executes the RV32M operation set at parametrised operand width. It sits beside the single-cycle ALU in the execute stage. The control unit starts an operation with a start/busy/done handshake and stalls the pipeline while the unit is busy. Radix-2 shift-add multiplication and restoring division are used: one bit per cycle, sharing one WIDTH+1-bit adder.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  input  WIDTH  rs1 operand (multiplicand/dividend); sampled with start.
b  input  WIDTH  rs2 operand (multiplier/divisor); sampled with start.
busy  output  1  high from the accepted start edge until done drops.
done  output  1  one-cycle pulse; result is valid while high.
result  output  WIDTH  registered result; holds until the next accepted start.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter and internal registers cleared. An in-flight operation is discarded.
- FSM states IDLE, RUN, FIN. busy=(state!=IDLE). done=(state==FIN).
- IDLE: start=1 at edge T0 latches op, a and b.
  - Normal path: go to RUN with counter=WIDTH.
  - Fast path: go directly to FIN.
  - start=0: stay in IDLE.
- RUN: one iteration per edge; counter decrements. The edge on which counter goes 1->0 writes result and moves to FIN. Normal latency: done is high in the cycle after edge T0+WIDTH, i.e. WIDTH+1 cycles of busy.
- FIN: lasts exactly one cycle, then IDLE. start is ignored in RUN and FIN; it is not queued. Back-to-back issue is possible in the first IDLE cycle.
- op and a/b changing after T0 has no effect.
- Operand preparation: signed operands are those of MULH (a, b), MULHSU (a only), DIV and REM (a, b).
  - Signed operands are converted to magnitudes, and the core runs unsigned.
  - Product sign = sign(a) XOR sign(b) over the signed operands only.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Negation is two's complement at WIDTH bits for division and 2*WIDTH bits for the product.
- Multiply: 2*WIDTH-bit product.
  - MUL returns the low WIDTH bits, which are identical for every signedness.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide: restoring algorithm. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Fast-path cases (latency 1: done is high the cycle after T0):
  - Divide by zero (b=0, any div/rem op): quotient = all ones; remainder = a.
  - Signed overflow (DIV/REM, a=most-negative, b=all ones): quotient = a; remainder = 0.
  - No exception or flag is raised in either case.
- result changes only on the FIN-entry edge and on reset.

Test Plan:
- WIDTH=32, MUL a=0x0000_1234 b=0x0000_5678, start pulsed 1 cycle -> busy high 33 cycles; done high exactly 1 cycle after edge T0+32; result=0x0626_0060; it then holds with done=0.
- MULH a=0xFFFF_FFFF (-1) b=0x0000_0002 -> result=0xFFFF_FFFF. MULHU same operands -> 0x0000_0001. MULHSU a=0xFFFF_FFFF b=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV a=0xFFFF_FFF9 (-7) b=2 -> 0xFFFF_FFFD (-3). REM same -> 0xFFFF_FFFF (-1). DIVU a=7 b=2 -> 3. REMU a=7 b=2 -> 1.
- DIVU a=0x1234_5678 b=0 -> done 1 cycle after start, result=0xFFFF_FFFF. REM a=0x8000_0000 b=0xFFFF_FFFF -> result=0 with 1-cycle latency. DIV with the same operands -> 0x8000_0000.
- Start a DIVU, hold start=1 and change a/b mid-RUN, then assert rst for 1 cycle at iteration 10 -> busy and done drop immediately, result=0. The next start (MUL 3*5) returns 15 after the normal latency.
- Two ops issued back-to-back in the first IDLE cycle after each done, with WIDTH=8 instance MULHU 0xFF*0xFF -> 0xFE (done after 9 cycles), then DIV 0x80/0xFF -> fast path 0x80.
